pmem_line_responder: RTL and testbench

//  Physical-memory responder for the L1 cache's pmem line interface: serves 128-bit line

---
 rtl/pmem_line_responder_pkg.sv | 6 +
 rtl/pmem_line_responder_line_store.sv | 16 +
 rtl/pmem_line_responder.sv | 72 +++++++
 tb/tb_pmem_line_responder.sv | 136 +++++++++++++
 4 files changed

// File: rtl/pmem_line_responder_pkg.sv
// pmem_line_responder_pkg: shared line/word types and FSM state encoding for the pmem responder
package pmem_line_responder_pkg;
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_memband;
  typedef enum logic [1:0] {PM_IDLE, PM_BUSY, PM_RESP} lc3b_pmem_state_t;
endpackage

// File: rtl/pmem_line_responder_line_store.sv
// line_store: line-granular backing store, synchronous write, combinational read, contents never reset
module line_store #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 4096
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk)
    if (we_i) mem_q[addr_i] <= wdata_i;
  assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/pmem_line_responder.sv
// pmem_line_responder: fixed-latency main-memory model answering 128-bit line reads/writes with a one-cycle resp
module pmem_line_responder
  import pmem_line_responder_pkg::*;
#(
  parameter int DEPTH   = 4096,
  parameter int LATENCY = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic         pmem_resp,
  output logic [127:0] pmem_rdata,
  output logic         pmem_error,
  output logic         busy
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  lc3b_pmem_state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idx_q;
  logic wr_q;
  lc3b_memband wdata_q, line_rd;
  logic commit, addr_unused;
  assign commit = (state_q == PM_BUSY) && (cnt_q == '0);
  // offset and alias bits of the byte address play no part in line selection
  assign addr_unused = ^pmem_address;
  // a reset landing on the commit edge must still discard the write
  line_store #(.WIDTH(128), .DEPTH(DEPTH)) u_store (
    .clk     (clk),
    .we_i    (commit && wr_q && !reset),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (line_rd)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state_q    <= PM_IDLE;
      cnt_q      <= '0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      pmem_error <= 1'b0;
      busy       <= 1'b0;
    end else begin
      pmem_resp  <= 1'b0;
      pmem_error <= 1'b0;
      case (state_q)
        PM_IDLE: if (pmem_read || pmem_write) begin
          idx_q      <= pmem_address[4 +: IW];
          wr_q       <= pmem_write;
          wdata_q    <= pmem_wdata;
          cnt_q      <= CW'(LATENCY - 1);
          pmem_error <= pmem_read && pmem_write;
          busy       <= 1'b1;
          state_q    <= PM_BUSY;
        end
        PM_BUSY: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        else begin
          if (!wr_q) pmem_rdata <= line_rd;
          pmem_resp <= 1'b1;
          state_q   <= PM_RESP;
        end
        PM_RESP: begin
          busy    <= 1'b0;
          state_q <= PM_IDLE;
        end
        default: state_q <= PM_IDLE;
      endcase
    end
endmodule

// File: tb/tb_pmem_line_responder.sv
// tb_pmem_line_responder: directed and random line transactions on three configurations vs. a line-map model
module tb_pmem_line_responder;
  localparam int LAT [3] = '{4, 1, 4};
  localparam int DEP [3] = '{4096, 4096, 16};
  logic clk = 1'b0, reset = 1'b1;
  logic rd [3], wr [3], resp [3], err [3], bsy [3];
  logic [15:0] addr [3];
  logic [127:0] wd [3], rdata [3], expd [3];
  logic [127:0] mem [int];
  int cyc = 0, n_chk = 0, n_fail = 0;
  int rc0, rc1, rc2, dummy;
  logic [127:0] d;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pmem_line_responder #(.DEPTH(4096), .LATENCY(4)) u4 (
    .clk(clk), .reset(reset), .pmem_read(rd[0]), .pmem_write(wr[0]), .pmem_address(addr[0]),
    .pmem_wdata(wd[0]), .pmem_resp(resp[0]), .pmem_rdata(rdata[0]), .pmem_error(err[0]), .busy(bsy[0]));
  pmem_line_responder #(.DEPTH(4096), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset), .pmem_read(rd[1]), .pmem_write(wr[1]), .pmem_address(addr[1]),
    .pmem_wdata(wd[1]), .pmem_resp(resp[1]), .pmem_rdata(rdata[1]), .pmem_error(err[1]), .busy(bsy[1]));
  pmem_line_responder #(.DEPTH(16), .LATENCY(4)) u16 (
    .clk(clk), .reset(reset), .pmem_read(rd[2]), .pmem_write(wr[2]), .pmem_address(addr[2]),
    .pmem_wdata(wd[2]), .pmem_resp(resp[2]), .pmem_rdata(rdata[2]), .pmem_error(err[2]), .busy(bsy[2]));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input int k, input string t, input logic [127:0] g, input logic [127:0] e);
    n_chk++;
    assert (g === e) else begin
      n_fail++;
      $error("FAIL %s[u%0d]: observed %h expected %h", t, k, g, e);
    end
  endtask
  function automatic int key(input int k, input logic [15:0] a);
    return k * 65536 + ((int'(a) >> 4) % DEP[k]);
  endfunction
  function automatic logic [127:0] look(input int kk);
    return mem.exists(kk) ? mem[kk] : '0;
  endfunction
  // drive one request in the current cycle (cycle 0) and follow it to the resp pulse
  task automatic xact(input int k, input bit r, input bit w, input logic [15:0] a, input logic [127:0] dat,
                      input bit drop, input bit scramble, output int rc);
    int n = 0;
    bit seen = 0;
    rd[k] = r; wr[k] = w; addr[k] = a; wd[k] = dat;
    while (!seen && n < 40) begin
      tick();
      n++;
      if (n == 1) begin
        chk(k, "error_pulse", 128'(err[k]), 128'(r & w));
        chk(k, "busy_on", 128'(bsy[k]), 128'd1);
      end
      if (scramble && n == 2) begin addr[k] = 16'($urandom); wd[k] = {4{$urandom}}; end
      seen = resp[k];
    end
    chk(k, "resp_cycle", 128'(n), 128'(LAT[k] + 1));
    if (w) mem[key(k, a)] = dat;
    else expd[k] = look(key(k, a));
    chk(k, "rdata", rdata[k], expd[k]);
    chk(k, "busy_resp", 128'(bsy[k]), 128'd1);
    rc = cyc;
    if (drop) begin rd[k] = 1'b0; wr[k] = 1'b0; end
    tick();
    chk(k, "resp_one_cycle", 128'(resp[k]), 128'd0);
    chk(k, "busy_off", 128'(bsy[k]), 128'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int k = 0; k < 3; k++) begin
      rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wd[k] = '0; expd[k] = '0;
    end
    repeat (3) tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk(k, "rst_resp", 128'(resp[k]), 128'd0);
      chk(k, "rst_rdata", rdata[k], 128'd0);
      chk(k, "rst_error", 128'(err[k]), 128'd0);
      chk(k, "rst_busy", 128'(bsy[k]), 128'd0);
    end
    // write then read the same line with a different byte offset
    xact(0, 0, 1, 16'h1230, {16{8'hA5}}, 1, 0, dummy);
    xact(0, 1, 0, 16'h123F, '0, 1, 0, dummy);
    // never-written line, then read/write/read back to back at latency 1
    xact(1, 1, 0, 16'h0040, '0, 1, 0, rc0);
    xact(1, 1, 0, 16'h0040, '0, 1, 0, rc0);
    xact(1, 0, 1, 16'h0040, {4{$urandom}}, 1, 0, rc1);
    xact(1, 1, 0, 16'h0040, '0, 1, 0, rc2);
    chk(1, "b2b_gap1", 128'(rc1 - rc0), 128'd3);
    chk(1, "b2b_gap2", 128'(rc2 - rc1), 128'd3);
    // simultaneous read and write is a write that also flags an error
    xact(0, 1, 1, 16'h0100, 128'd1, 1, 0, dummy);
    tick();
    xact(0, 1, 0, 16'h0100, '0, 1, 0, dummy);
    // reset during BUSY discards the pending write
    xact(0, 0, 1, 16'h0200, {4{$urandom}}, 1, 0, dummy);
    wr[0] = 1'b1; addr[0] = 16'h0200; wd[0] = '1;
    tick();
    tick();
    reset = 1'b1; wr[0] = 1'b0;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) expd[k] = '0;
    chk(0, "abort_busy", 128'(bsy[0]), 128'd0);
    chk(0, "abort_rdata", rdata[0], 128'd0);
    for (int i = 0; i < 6; i++) begin
      chk(0, "abort_no_resp", 128'(resp[0]), 128'd0);
      tick();
    end
    xact(0, 1, 0, 16'h0200, '0, 1, 0, dummy);
    // mid-transaction input changes are ignored; held request starts a second transaction
    d = {4{$urandom}};
    xact(0, 0, 1, 16'h0300, d, 0, 1, dummy);
    xact(0, 1, 0, 16'h0300, '0, 1, 0, dummy);
    // 16-line store aliases on address bits [7:4]
    d = {4{$urandom}};
    xact(2, 0, 1, 16'h0010, d, 1, 0, dummy);
    xact(2, 1, 0, 16'h0110, '0, 1, 0, dummy);
    // random traffic on every configuration
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 24; i++) begin
        logic [15:0] a;
        int op;
        a = 16'($urandom) & (k == 2 ? 16'hFF7F : 16'h307F);
        op = $urandom_range(0, 7);
        xact(k, op != 7 && op[0], op == 7 || !op[0], a, {4{$urandom}}, 1, op == 3, dummy);
        repeat ($urandom_range(0, 2)) tick();
      end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
